// File: rtl/dm_sba_engine_if.sv
// System bus port bundle for the debug module SBA engine.
// master: request side (req/we/add/be/wdata out, gnt/r_valid/r_err/r_rdata in).
interface dm_sba_engine_if;
    logic        req;
    logic        we;
    logic [31:0] add;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        gnt;
    logic        r_valid;
    logic        r_err;
    logic [31:0] r_rdata;

    modport master (
        output req, we, add, be, wdata,
        input  gnt, r_valid, r_err, r_rdata
    );

    modport slave (
        input  req, we, add, be, wdata,
        output gnt, r_valid, r_err, r_rdata
    );
endinterface

// File: rtl/dm_sba_engine.sv
// Debug module system bus access engine: turns sbaddress0/sbdata0 accesses
// into single-beat bus transactions with alignment, busy and bus error checks.
// Ports: clk_i, rst_i (sync, active-high), dmactive_i (soft reset),
//   sbaddress/sbdata register strobes and sbcs control bits in,
//   sbaddress_o/sbdata_o plus status strobes out, master = system bus port.
module dm_sba_engine #(
    parameter int BusWidth = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                dmactive_i,
    input  logic [31:0]         sbaddress_i,
    input  logic                sbaddress_we_i,
    input  logic [BusWidth-1:0] sbdata_i,
    input  logic                sbdata_we_i,
    input  logic                sbdata_re_i,
    input  logic                sbreadonaddr_i,
    input  logic                sbreadondata_i,
    input  logic                sbautoincrement_i,
    input  logic [2:0]          sbaccess_i,
    output logic [31:0]         sbaddress_o,
    output logic [BusWidth-1:0] sbdata_o,
    output logic                sbdata_valid_o,
    output logic                sbbusy_o,
    output logic                sbbusyerror_o,
    output logic                sberror_valid_o,
    output logic [2:0]          sberror_o,
    dm_sba_engine_if.master     master
);

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StWrite,
        StWaitRead,
        StWaitWrite
    } state_e;

    state_e        state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          rvalid_q, rvalid_d;
    logic          busyerr_q, busyerr_d;
    logic          errv_q, errv_d;
    logic [2:0]    err_q, err_d;
    logic          req_q, req_d;
    logic          we_q, we_d;
    logic [31:0]   add_q, add_d;
    logic [3:0]    be_q, be_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [1:0]    size_q, size_d;
    logic          abort_q, abort_d;

    logic [31:0]   eff_addr;
    logic          launch_rd;
    logic          launch_wr;
    logic          misalign;
    logic [3:0]    be_mask;
    logic [31:0]   rd_shift;
    logic [31:0]   rd_ext;
    logic          discard;

    always_comb begin
        // A read-on-address launch targets the address being written now
        eff_addr  = sbaddress_we_i ? sbaddress_i : addr_q;
        launch_wr = sbdata_we_i;
        launch_rd = (sbaddress_we_i && sbreadonaddr_i)
                 || (sbdata_re_i && sbreadondata_i);
        misalign  = ((sbaccess_i == 3'd1) && eff_addr[0])
                 || ((sbaccess_i == 3'd2) && (eff_addr[1:0] != 2'b00));
        unique case (sbaccess_i[1:0])
            2'd0:    be_mask = 4'b0001;
            2'd1:    be_mask = 4'b0011;
            default: be_mask = 4'b1111;
        endcase
        rd_shift = master.r_rdata >> {addr_q[1:0], 3'b000};
        unique case (size_q)
            2'd0:    rd_ext = {24'd0, rd_shift[7:0]};
            2'd1:    rd_ext = {16'd0, rd_shift[15:0]};
            default: rd_ext = rd_shift;
        endcase
        // Responses to a request orphaned by dmactive low are dropped
        discard = abort_q || !dmactive_i;
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rdata_d   = rdata_q;
        rvalid_d  = 1'b0;
        busyerr_d = 1'b0;
        errv_d    = 1'b0;
        err_d     = err_q;
        req_d     = req_q;
        we_d      = we_q;
        add_d     = add_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        size_d    = size_q;
        abort_d   = abort_q;

        if (state_q != StIdle
            && (sbaddress_we_i || sbdata_we_i || sbdata_re_i)) begin
            busyerr_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (dmactive_i) begin
                    if (sbaddress_we_i) begin
                        addr_d = sbaddress_i;
                    end
                    if (launch_wr || launch_rd) begin
                        if (sbaccess_i > 3'd2) begin
                            errv_d = 1'b1;
                            err_d  = 3'd4;
                        end else if (misalign) begin
                            errv_d = 1'b1;
                            err_d  = 3'd3;
                        end else begin
                            state_d = launch_wr ? StWrite : StRead;
                            req_d   = 1'b1;
                            we_d    = launch_wr;
                            add_d   = {eff_addr[31:2], 2'b00};
                            be_d    = be_mask << eff_addr[1:0];
                            size_d  = sbaccess_i[1:0];
                            if (launch_wr) begin
                                wdata_d = sbdata_i << {eff_addr[1:0], 3'b000};
                            end
                        end
                    end
                end
            end
            StRead, StWrite: begin
                if (master.gnt) begin
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    abort_d = !dmactive_i;
                    state_d = (state_q == StRead) ? StWaitRead : StWaitWrite;
                end else if (!dmactive_i) begin
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    state_d = StIdle;
                end
            end
            StWaitRead, StWaitWrite: begin
                if (!dmactive_i) begin
                    abort_d = 1'b1;
                end
                if (master.r_valid) begin
                    state_d = StIdle;
                    abort_d = 1'b0;
                    if (!discard) begin
                        if (master.r_err) begin
                            errv_d = 1'b1;
                            err_d  = 3'd2;
                        end else begin
                            if (state_q == StWaitRead) begin
                                rdata_d  = rd_ext;
                                rvalid_d = 1'b1;
                            end
                            if (sbautoincrement_i) begin
                                addr_d = addr_q + (32'd1 << size_q);
                            end
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            busyerr_q <= 1'b0;
            errv_q    <= 1'b0;
            err_q     <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            add_q     <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            size_q    <= '0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
            busyerr_q <= busyerr_d;
            errv_q    <= errv_d;
            err_q     <= err_d;
            req_q     <= req_d;
            we_q      <= we_d;
            add_q     <= add_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            size_q    <= size_d;
            abort_q   <= abort_d;
        end
    end

    assign sbaddress_o     = addr_q;
    assign sbdata_o        = rdata_q;
    assign sbdata_valid_o  = rvalid_q;
    assign sbbusy_o        = (state_q != StIdle);
    assign sbbusyerror_o   = busyerr_q;
    assign sberror_valid_o = errv_q;
    assign sberror_o       = err_q;
    assign master.req      = req_q;
    assign master.we       = we_q;
    assign master.add      = add_q;
    assign master.be       = be_q;
    assign master.wdata    = wdata_q;

endmodule
